// File: rtl/execute_cycle_pkg.sv
// Shared definitions for the execute stage: ALU operation codes, forwarding
// selects and the EX/MEM pipeline register layout.
package execute_cycle_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_op_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic        result_src;
      logic [31:0] alu_result;
      logic [31:0] write_data;
      logic [31:0] pc_plus4;
      logic [4:0]  rd;
   } exmem_t;

   // The reserved select 11 falls back to the register-file value.
   function automatic logic [31:0] fwd_select(
      input logic [1:0]  sel,
      input logic [31:0] rf_val,
      input logic [31:0] wb_val,
      input logic [31:0] mem_val
   );
      logic [31:0] val;
      val = rf_val;
      if (sel == FWD_WB)
         val = wb_val;
      else if (sel == FWD_MEM)
         val = mem_val;
      return val;
   endfunction

endpackage

// File: rtl/execute_cycle_alu.sv
// 32-bit ALU for the execute stage: add, sub, and, or, signed set-less-than.
// Unused operation codes produce zero.
module alu
   import execute_cycle_pkg::*;
(
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  ALUControl,
   output logic [31:0] Result,
   output logic        Zero
);

   logic w_lt;

   assign w_lt = ($signed(A) < $signed(B));

   always_comb begin
      Result = '0;
      case (ALUControl)
         ALU_ADD: Result = A + B;
         ALU_SUB: Result = A - B;
         ALU_AND: Result = A & B;
         ALU_OR:  Result = A | B;
         ALU_SLT: Result = {31'b0, w_lt};
         default: Result = '0;
      endcase
   end

   assign Zero = (Result == 32'd0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage of the pipeline: operand forwarding, ALU, beq resolution and
// the EX/MEM pipeline register.
module execute_cycle
   import execute_cycle_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteE,
   input  logic        MemWriteE,
   input  logic        ResultSrcE,
   input  logic        ALUSrcE,
   input  logic        BranchE,
   input  logic [2:0]  ALUControlE,
   input  logic [31:0] RD1_E,
   input  logic [31:0] RD2_E,
   input  logic [31:0] Imm_Ext_E,
   input  logic [4:0]  RD_E,
   input  logic [31:0] PCE,
   input  logic [31:0] PCPlus4E,
   input  logic [1:0]  ForwardA_E,
   input  logic [1:0]  ForwardB_E,
   input  logic [31:0] ResultW,
   output logic        PCSrcE,
   output logic [31:0] PCTargetE,
   output logic        RegWriteM,
   output logic        MemWriteM,
   output logic        ResultSrcM,
   output logic [31:0] ALUResultM,
   output logic [31:0] WriteDataM,
   output logic [31:0] PCPlus4M,
   output logic [4:0]  RD_M
);

   logic [31:0] w_src_a;
   logic [31:0] w_fwd_b;
   logic [31:0] w_src_b;
   logic [31:0] w_alu_result;
   logic        w_zero;
   exmem_t      r_exmem;

   // MEM forwarding reads the value already held in EX/MEM, so a dependent
   // instruction right behind its producer needs no stall.
   assign w_src_a = fwd_select(ForwardA_E, RD1_E, ResultW, r_exmem.alu_result);
   assign w_fwd_b = fwd_select(ForwardB_E, RD2_E, ResultW, r_exmem.alu_result);
   assign w_src_b = ALUSrcE ? Imm_Ext_E : w_fwd_b;

   alu u_alu (
      .A          (w_src_a),
      .B          (w_src_b),
      .ALUControl (ALUControlE),
      .Result     (w_alu_result),
      .Zero       (w_zero)
   );

   assign PCSrcE    = BranchE & w_zero;
   assign PCTargetE = PCE + Imm_Ext_E;

   // Store data is always the forwarded rs2, never the immediate.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_exmem <= '0;
      end else begin
         r_exmem.reg_write  <= RegWriteE;
         r_exmem.mem_write  <= MemWriteE;
         r_exmem.result_src <= ResultSrcE;
         r_exmem.alu_result <= w_alu_result;
         r_exmem.write_data <= w_fwd_b;
         r_exmem.pc_plus4   <= PCPlus4E;
         r_exmem.rd         <= RD_E;
      end
   end

   assign RegWriteM  = r_exmem.reg_write;
   assign MemWriteM  = r_exmem.mem_write;
   assign ResultSrcM = r_exmem.result_src;
   assign ALUResultM = r_exmem.alu_result;
   assign WriteDataM = r_exmem.write_data;
   assign PCPlus4M   = r_exmem.pc_plus4;
   assign RD_M       = r_exmem.rd;

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed cases plus randomized
// traffic compared against a behavioural model of the execute stage.
module tb_execute_cycle;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
   logic [4:0]  RD_E;
   logic [1:0]  ForwardA_E, ForwardB_E;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        RegWriteM, MemWriteM, ResultSrcM;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
   logic [4:0]  RD_M;

   int n_checks = 0;
   int n_pass   = 0;

   // Model of the EX/MEM contents
   logic        m_regw, m_memw, m_rsrc;
   logic [31:0] m_alu, m_wd, m_pc4;
   logic [4:0]  m_rd;

   always #5 clk = ~clk;

   execute_cycle dut (
      .clk(clk), .rst(rst),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
      .ALUSrcE(ALUSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
      .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
      .PCE(PCE), .PCPlus4E(PCPlus4E), .ForwardA_E(ForwardA_E),
      .ForwardB_E(ForwardB_E), .ResultW(ResultW),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
      .RD_M(RD_M)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      else
         n_pass++;
   endtask

   function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                        input logic [31:0] wb, input logic [31:0] mem);
      if (sel == 2'd1) return wb;
      if (sel == 2'd2) return mem;
      return rf;
   endfunction

   function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int signed sa, sb;
      sa = a;
      sb = b;
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_clear();
      m_regw = 0; m_memw = 0; m_rsrc = 0;
      m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0;
   endtask

   task automatic clear_inputs();
      RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; ALUSrcE = 0; BranchE = 0;
      ALUControlE = 0; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; RD_E = 0;
      PCE = 0; PCPlus4E = 0; ForwardA_E = 0; ForwardB_E = 0; ResultW = 0;
   endtask

   task automatic rand_inputs();
      RegWriteE   = 1'($urandom);
      MemWriteE   = 1'($urandom);
      ResultSrcE  = 1'($urandom);
      ALUSrcE     = 1'($urandom);
      BranchE     = 1'($urandom);
      ALUControlE = 3'($urandom);
      RD1_E       = $urandom;
      RD2_E       = ($urandom_range(3) == 0) ? RD1_E : $urandom;
      Imm_Ext_E   = $urandom;
      RD_E        = 5'($urandom);
      PCE         = $urandom;
      PCPlus4E    = PCE + 32'd4;
      ForwardA_E  = 2'($urandom);
      ForwardB_E  = 2'($urandom);
      ResultW     = ($urandom_range(4) == 0) ? RD1_E : $urandom;
   endtask

   task automatic check_regs(input string tag);
      check({tag, "_alu"},  ALUResultM, m_alu);
      check({tag, "_wd"},   WriteDataM, m_wd);
      check({tag, "_pc4"},  PCPlus4M, m_pc4);
      check({tag, "_ctrl"}, {24'd0, RegWriteM, MemWriteM, ResultSrcM, RD_M},
                            {24'd0, m_regw, m_memw, m_rsrc, m_rd});
   endtask

   // Check combinational outputs, clock once, then check EX/MEM against the model.
   task automatic step(input string tag);
      logic [31:0] a, fb, b, r;
      a  = pick(ForwardA_E, RD1_E, ResultW, m_alu);
      fb = pick(ForwardB_E, RD2_E, ResultW, m_alu);
      b  = ALUSrcE ? Imm_Ext_E : fb;
      r  = ref_alu(ALUControlE, a, b);
      #1;
      check({tag, "_pcsrc"}, {31'd0, PCSrcE}, {31'd0, BranchE && (r == 32'd0)});
      check({tag, "_pctgt"}, PCTargetE, PCE + Imm_Ext_E);
      @(posedge clk);
      m_regw = RegWriteE; m_memw = MemWriteE; m_rsrc = ResultSrcE;
      m_alu = r; m_wd = fb; m_pc4 = PCPlus4E; m_rd = RD_E;
      #1;
      check_regs(tag);
   endtask

   initial begin
      clear_inputs();
      model_clear();
      rst = 1'b0;

      // Reset held with random inputs: EX/MEM stays zero, branch target stays live
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         rand_inputs();
         #1;
         check("rst_pctgt", PCTargetE, PCE + Imm_Ext_E);
         @(posedge clk);
         #1;
         check_regs("rst_hold");
      end
      @(negedge clk);
      rand_inputs();
      rst = 1'b1;
      step("rst_release");

      // Simple add
      clear_inputs();
      RD1_E = 5; RD2_E = 7; RD_E = 3; RegWriteE = 1;
      step("add");
      check("add_const", ALUResultM, 32'd12);
      check("add_wd", WriteDataM, 32'd7);

      // Back-to-back dependency through MEM forwarding
      clear_inputs();
      ForwardA_E = 2'b10; ALUSrcE = 1; Imm_Ext_E = 4;
      step("fwd_mem");
      check("fwd_mem_const", ALUResultM, 32'd16);

      // beq taken / not taken
      clear_inputs();
      BranchE = 1; ALUControlE = 3'b001; RD1_E = 9; RD2_E = 9; PCE = 32'h100; Imm_Ext_E = 32'h20;
      #1;
      check("beq_taken", {31'd0, PCSrcE}, 32'd1);
      check("beq_target", PCTargetE, 32'h120);
      RD2_E = 8;
      #1;
      check("beq_not_taken", {31'd0, PCSrcE}, 32'd0);
      step("beq");

      // Signed compare and wrap-around add
      clear_inputs();
      ALUControlE = 3'b101; RD1_E = 32'hFFFF_FFFF; RD2_E = 1;
      step("slt_neg");
      check("slt_neg_const", ALUResultM, 32'd1);
      RD1_E = 1; RD2_E = 32'hFFFF_FFFF;
      step("slt_pos");
      check("slt_pos_const", ALUResultM, 32'd0);
      ALUControlE = 3'b000; RD1_E = 32'hFFFF_FFFF; RD2_E = 1; BranchE = 1;
      #1;
      check("add_wrap_zero", {31'd0, PCSrcE}, 32'd1);
      step("add_wrap");
      check("add_wrap_const", ALUResultM, 32'd0);

      // Store data forwarded from write-back while operand B is the immediate
      clear_inputs();
      ForwardB_E = 2'b01; ResultW = 32'hDEAD; ALUSrcE = 1; Imm_Ext_E = 8;
      MemWriteE = 1; RD1_E = 32'h10; RD2_E = 32'h55;
      step("store_fwd");
      check("store_wd_const", WriteDataM, 32'hDEAD);
      check("store_alu_const", ALUResultM, 32'h18);

      // Randomized traffic, with one asynchronous reset pulse mid-stream
      for (int i = 0; i < 300; i++) begin
         rand_inputs();
         step("rand");
         if (i == 150) begin
            rst = 1'b0;
            #1;
            model_clear();
            check_regs("async_rst");
            rst = 1'b1;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 clk  input  1  pipeline clock; all registers update on the rising edge.
REQ-002 rst  input  1  reset; asynchronous, active-low.
REQ-003 RegWriteE, MemWriteE, ResultSrcE  input  1 each  ID/EX control bits passed through to EX/MEM.
REQ-004 ALUSrcE  input  1  selects ALU operand B: 1 = Imm_Ext_E, 0 = forwarded register value.
REQ-005 BranchE  input  1  marks the instruction as beq.
REQ-006 ALUControlE  input  3  ALU operation code.
REQ-007 RD1_E, RD2_E  input  32 each  register-file operands rs1 and rs2.
REQ-008 Imm_Ext_E  input  32  sign-extended immediate.
REQ-009 RD_E  input  5  destination register index.
REQ-010 PCE, PCPlus4E  input  32 each  instruction PC and PC+4.
REQ-011 ForwardA_E, ForwardB_E  input  2 each  operand forwarding selects from the hazard unit.
REQ-012 ResultW  input  32  write-back result, used for forwarding.
REQ-013 PCSrcE  output  1  branch taken; combinational.
REQ-014 PCTargetE  output  32  branch target; combinational.
REQ-015 RegWriteM, MemWriteM, ResultSrcM  output  1 each  registered control bits.
REQ-016 ALUResultM, WriteDataM, PCPlus4M  output  32 each  registered data.
REQ-017 RD_M  output  5  registered destination register index.

Function
REQ-018 SrcA SHALL be selected by ForwardA_E: RD1_E for 00, ResultW for 01, ALUResultM for 10, RD1_E for 11 (reserved).
REQ-019 FwdB SHALL be selected the same way from RD2_E, ResultW and ALUResultM by ForwardB_E; SrcB SHALL be Imm_Ext_E when ALUSrcE=1, otherwise FwdB.
REQ-020 The ALU SHALL implement: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 101 signed A<B ? 1 : 0; every other code SHALL give 0; add and sub wrap modulo 2^32 with no overflow output.
REQ-021 Zero SHALL equal (ALU result == 0); PCSrcE SHALL equal BranchE & Zero in the same cycle, unregistered.
REQ-022 PCTargetE SHALL equal PCE + Imm_Ext_E modulo 2^32, independent of ALUSrcE and ForwardX.
REQ-023 On each rising clk edge with rst=1, EX/MEM SHALL capture RegWriteE, MemWriteE, ResultSrcE, the ALU result, FwdB as WriteDataM (never the immediate), RD_E and PCPlus4E; latency is 1 cycle.
REQ-024 ForwardX=10 SHALL use the ALUResultM value held before the edge, so a back-to-back dependent instruction completes with no stall.
REQ-025 ForwardA_E and ForwardB_E both equal to 10 or both equal to 01 is legal; both operands then receive the same value.
REQ-026 There SHALL be no enable or stall input; EX/MEM updates every cycle; bubbles arrive as zeroed control bits from ID/EX.
REQ-027 An X-free input set SHALL give X-free outputs; the reserved codes 11 and unused ALU codes are defined per REQ-018 and REQ-020.

Reset
REQ-028 While rst=0, every EX/MEM output (RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, RD_M) SHALL be 0 immediately, independent of clk.
REQ-029 PCSrcE and PCTargetE SHALL stay combinational functions of the inputs during reset; the first rising edge after rst=1 SHALL load normal values.

Structure
REQ-030 A shared package SHALL hold the ALU codes (ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SLT=101) and the forward selects (FWD_RF=00, FWD_WB=01, FWD_MEM=10).
REQ-031 There SHALL be one sub-module, alu (A 32, B 32, ALUControl 3 -> Result 32, Zero 1); the forwarding muxes, branch logic and EX/MEM register live in execute_cycle.

Verification
REQ-032 Hold rst=0 with random inputs and clk toggling -> all EX/MEM outputs stay 0; release -> the first edge loads the inputs.
REQ-033 RD1_E=5, RD2_E=7, ALUControlE=000, ALUSrcE=0, Fwd=00, RD_E=3, RegWriteE=1 -> after 1 edge ALUResultM=12, WriteDataM=7, RD_M=3, RegWriteM=1.
REQ-034 Previous result ALUResultM=12, then ForwardA_E=10, RD1_E=0, ALUSrcE=1, Imm_Ext_E=4, add -> ALUResultM=16.
REQ-035 BranchE=1, ALUControlE=001, RD1_E=RD2_E=9, PCE=0x100, Imm_Ext_E=0x20 -> PCSrcE=1, PCTargetE=0x120 same cycle; with RD2_E=8 -> PCSrcE=0.
REQ-036 SLT with A=0xFFFFFFFF, B=1 -> 1; SLT with A=1, B=0xFFFFFFFF -> 0; ADD 0xFFFFFFFF+1 -> 0, with Zero=1.
REQ-037 ForwardB_E=01, ResultW=0xDEAD, ALUSrcE=1, Imm_Ext_E=8, MemWriteE=1 -> WriteDataM=0xDEAD, MemWriteM=1, ALUResultM = SrcA+8.
